// File: rtl/conv_stage_stream.sv
// Streaming NxN convolution stage: window FIFO, runtime-loadable kernel bank, PE-wide
// dot products emitted as Groups output groups per window with valid/ready on both sides.
module conv_stage_stream #(
   parameter int NumberOfK          = 8,
   parameter int N                  = 3,
   parameter int BitSize            = 8,
   parameter int KernelBitSize      = 8,
   parameter int ProcessingElements = 4,
   parameter int Depth              = 4,
   parameter int FracShift          = 0,
   localparam int Groups            = NumberOfK / ProcessingElements,
   localparam int GW                = (Groups > 1) ? $clog2(Groups) : 1,
   localparam int KAW               = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
   input  logic                                          clk,
   input  logic                                          res,
   input  logic                                          relu_en,
   input  logic                                          k_we,
   input  logic [KAW-1:0]                                k_addr,
   input  logic [N*N*KernelBitSize-1:0]                  k_data,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [N*N*BitSize-1:0]                        in_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [ProcessingElements-1:0][BitSize-1:0]    out_data,
   output logic [GW-1:0]                                 out_group,
   output logic                                          out_last
);

   localparam int NE   = N * N;
   localparam int SumW = BitSize + KernelBitSize + $clog2(NE) + 1;
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   localparam logic signed [SumW-1:0] SatMax = SumW'((2 ** (BitSize - 1)) - 1);
   localparam logic signed [SumW-1:0] SatMin = -SatMax - SumW'(1);

   logic [NE*KernelBitSize-1:0]                 r_kern [NumberOfK];
   logic [NE*BitSize-1:0]                       r_fifo [Depth];
   logic [PtrW-1:0]                             r_wr_ptr;
   logic [PtrW-1:0]                             r_rd_ptr;
   logic [CntW-1:0]                             r_count;
   logic [GW-1:0]                               r_grp;
   logic                                        r_out_valid;
   logic [ProcessingElements-1:0][BitSize-1:0]  r_out_data;
   logic [GW-1:0]                               r_out_group;
   logic                                        r_out_last;

   logic                                        w_push;
   logic                                        w_load;
   logic                                        w_pop;
   logic                                        w_idle;
   logic                                        w_last_grp;
   logic [NE*BitSize-1:0]                       w_head;
   logic [KAW-1:0]                              w_kidx;
   logic [ProcessingElements-1:0][BitSize-1:0]  w_result;

   function automatic logic signed [SumW-1:0] dot(input logic [NE*BitSize-1:0]       win,
                                                  input logic [NE*KernelBitSize-1:0] kern);
      logic signed [SumW-1:0] acc;
      logic signed [SumW-1:0] px;
      logic signed [SumW-1:0] cf;
      acc = '0;
      for (int e = 0; e < NE; e++) begin
         px  = SumW'($signed(win[e*BitSize +: BitSize]));
         cf  = SumW'($signed(kern[e*KernelBitSize +: KernelBitSize]));
         acc = acc + px * cf;
      end
      return acc;
   endfunction

   function automatic logic [BitSize-1:0] rescale(input logic signed [SumW-1:0] sum,
                                                  input logic                   relu);
      logic signed [SumW-1:0] v;
      v = sum >>> FracShift;
      if (relu && v[SumW-1]) v = '0;
      if (v > SatMax) v = SatMax;
      if (v < SatMin) v = SatMin;
      return v[BitSize-1:0];
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_head     = r_fifo[r_rd_ptr];
   assign w_idle     = (r_count == '0) && !r_out_valid;
   assign w_last_grp = (r_grp == GW'(Groups - 1));
   assign in_ready   = !res && (r_count < CntW'(Depth));
   assign w_push     = in_valid && in_ready;
   assign w_load     = (r_count != '0) && (!r_out_valid || out_ready);
   assign w_pop      = w_load && w_last_grp;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_result = '0;
      w_kidx   = '0;
      for (int p = 0; p < ProcessingElements; p++) begin
         w_kidx      = KAW'(int'(r_grp) * ProcessingElements + p);
         w_result[p] = rescale(dot(w_head, r_kern[w_kidx]), relu_en);
      end
   end

   // NOTE: the kernel bank must read zero after reset, so unlike the FIFO storage it is cleared.
   always_ff @(posedge clk) begin
      if (res) begin
         for (int k = 0; k < NumberOfK; k++) r_kern[k] <= '0;
      end else if (k_we && w_idle) begin
         r_kern[k_addr] <= k_data;
      end
   end

   // FIFO payload needs no reset: the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= in_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (res) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_grp       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_group <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_group <= r_grp;
            r_out_last  <= w_last_grp;
            r_grp       <= w_last_grp ? '0 : r_grp + 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_group = r_out_group;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_stage_stream.sv
// Scoreboard bench for conv_stage_stream: expected groups are queued when a window is
// accepted and compared when the stage hands a group downstream.
module tb_conv_stage_stream;
   localparam int N      = 3;
   localparam int BW     = 8;
   localparam int KW     = 8;
   localparam int NK     = 4;
   localparam int PE     = 2;
   localparam int DEPTH  = 4;
   localparam int FRAC   = 0;
   localparam int NE     = N * N;
   localparam int GROUPS = NK / PE;

   logic                   clk = 1'b0;
   logic                   res;
   logic                   relu_en;
   logic                   k_we;
   logic [1:0]             k_addr;
   logic [NE*KW-1:0]       k_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [NE*BW-1:0]       in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [PE-1:0][BW-1:0]  out_data;
   logic [0:0]             out_group;
   logic                   out_last;

   typedef struct {
      logic [PE-1:0][BW-1:0] data;
      int                    grp;
      logic                  last;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_x;
   logic [NE*KW-1:0] kmodel [NK];
   int               n_checks = 0;
   int               n_errors = 0;
   int               n_out    = 0;

   conv_stage_stream #(
      .NumberOfK(NK), .N(N), .BitSize(BW), .KernelBitSize(KW),
      .ProcessingElements(PE), .Depth(DEPTH), .FracShift(FRAC)
   ) dut (
      .clk(clk), .res(res), .relu_en(relu_en), .k_we(k_we), .k_addr(k_addr),
      .k_data(k_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_group(out_group), .out_last(out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [NE*BW-1:0] fill(input int v);
      logic [NE*BW-1:0] w;
      for (int e = 0; e < NE; e++) w[e*BW +: BW] = BW'(v);
      return w;
   endfunction

   function automatic logic [NE*BW-1:0] rand_vec();
      logic [NE*BW-1:0] w;
      for (int e = 0; e < NE; e++) w[e*BW +: BW] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   function automatic logic [BW-1:0] model_out(input logic [NE*KW-1:0] kern,
                                               input logic [NE*BW-1:0] win,
                                               input logic             relu);
      int               sum;
      logic signed [7:0] a;
      logic signed [7:0] b;
      sum = 0;
      for (int e = 0; e < NE; e++) begin
         a   = kern[e*KW +: KW];
         b   = win[e*BW +: BW];
         sum = sum + int'(a) * int'(b);
      end
      sum = sum >>> FRAC;
      if (relu && sum < 0) sum = 0;
      if (sum > 127)  sum = 127;
      if (sum < -128) sum = -128;
      return sum[BW-1:0];
   endfunction

   task automatic sb_push(input logic [NE*BW-1:0] w, input logic relu);
      exp_t x;
      for (int g = 0; g < GROUPS; g++) begin
         for (int p = 0; p < PE; p++) x.data[p] = model_out(kmodel[g*PE + p], w, relu);
         x.grp  = g;
         x.last = (g == GROUPS - 1);
         sb.push_back(x);
      end
   endtask

   // Handshakes are judged at the falling edge, where inputs and outputs are settled.
   always @(negedge clk) begin
      if (!res) begin
         if (in_valid && in_ready) sb_push(in_data, relu_en);
         if (out_valid && out_ready) begin
            n_checks++;
            n_out++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL sb_unexpected: got data %h grp %0d last %0b, required no output",
                        out_data, out_group, out_last);
            end else begin
               mon_x = sb.pop_front();
               if (out_data !== mon_x.data || int'(out_group) !== mon_x.grp || out_last !== mon_x.last) begin
                  n_errors++;
                  $display("FAIL sb_group: got data %h grp %0d last %0b, required data %h grp %0d last %0b",
                           out_data, out_group, out_last, mon_x.data, mon_x.grp, mon_x.last);
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_window(input logic [NE*BW-1:0] w);
      bit acc;
      int t;
      in_data  = w;
      in_valid = 1'b1;
      acc      = 1'b0;
      t        = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 500) begin
         tick();
         t++;
      end
      n_checks++;
      if (sb.size() != 0 || out_valid) begin
         n_errors++;
         $display("FAIL %s_drain: %0d groups outstanding out_valid %0b, required 0 and 0",
                  name, sb.size(), out_valid);
      end
   endtask

   task automatic write_kernel(input int idx, input logic [NE*KW-1:0] d, input bit model_upd);
      k_we   = 1'b1;
      k_addr = 2'(idx);
      k_data = d;
      tick();
      k_we   = 1'b0;
      if (model_upd) kmodel[idx] = d;
   endtask

   task automatic load_std_kernels();
      logic [NE*KW-1:0] centre;
      centre           = '0;
      centre[4*KW +: KW] = 8'd1;
      write_kernel(0, fill(1), 1'b1);
      write_kernel(1, fill(2), 1'b1);
      write_kernel(2, centre, 1'b1);
      write_kernel(3, fill(-1), 1'b1);
   endtask

   task automatic test_reset();
      res = 1'b1; relu_en = 1'b0; k_we = 1'b0; k_addr = '0; k_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      for (int k = 0; k < NK; k++) kmodel[k] = '0;
      tick(2);
      n_checks++;
      if (out_valid !== 1'b0 || out_group !== 1'b0 || out_last !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got valid %b grp %b last %b, required 0 0 0", out_valid, out_group, out_last);
      end
      n_checks++;
      if (out_data !== '0) begin
         n_errors++;
         $display("FAIL reset_data: got %h, required 0000", out_data);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b while res high, required 0", in_ready);
      end
      res = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      load_std_kernels();
      push_window(fill(3));
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_latency: out_valid %b right after push edge, required 0", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_group !== 1'b0 || out_last !== 1'b0 || out_data !== {8'd54, 8'd27}) begin
         n_errors++;
         $display("FAIL basic_grp0: got v%b g%0d l%b %h, required v1 g0 l0 361b", out_valid, out_group, out_last, out_data);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_group !== 1'b1 || out_last !== 1'b1 || out_data !== {8'he5, 8'd3}) begin
         n_errors++;
         $display("FAIL basic_grp1: got v%b g%0d l%b %h, required v1 g1 l1 e503", out_valid, out_group, out_last, out_data);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_idle: out_valid %b after last group, required 0", out_valid);
      end
      wait_drain("basic");
   endtask

   task automatic test_saturation();
      relu_en = 1'b0;
      push_window(fill(100));
      tick();
      n_checks++;
      if (out_data !== {8'h7f, 8'h7f} || out_group !== 1'b0) begin
         n_errors++;
         $display("FAIL sat_grp0: got g%0d %h, required g0 7f7f", out_group, out_data);
      end
      tick();
      n_checks++;
      if (out_data !== {8'h80, 8'd100} || out_group !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_grp1: got g%0d %h, required g1 8064", out_group, out_data);
      end
      wait_drain("sat");
      relu_en = 1'b1;
      push_window(fill(100));
      tick(2);
      n_checks++;
      if (out_data !== {8'h00, 8'd100} || out_last !== 1'b1) begin
         n_errors++;
         $display("FAIL relu_grp1: got l%b %h, required l1 0064", out_last, out_data);
      end
      wait_drain("relu");
      relu_en = 1'b0;
   endtask

   task automatic test_backpressure();
      int accepted;
      int base;
      accepted  = 0;
      base      = n_out;
      out_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_data  = fill(accepted + 1);
         in_valid = (accepted < 6);
         @(negedge clk);
         if (in_valid && in_ready) accepted++;
         @(posedge clk);
         #1;
         if (out_valid) begin
            n_checks++;
            if (out_data !== {8'd18, 8'd9} || out_group !== 1'b0) begin
               n_errors++;
               $display("FAIL bp_frozen: cycle %0d got g%0d %h, required g0 1209", c, out_group, out_data);
            end
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (accepted != 4 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_full: accepted %0d in_ready %b, required 4 and 0", accepted, in_ready);
      end
      out_ready = 1'b1;
      while (accepted < 6) begin
         push_window(fill(accepted + 1));
         accepted++;
      end
      wait_drain("bp");
      n_checks++;
      if (n_out - base != 12) begin
         n_errors++;
         $display("FAIL bp_count: got %0d groups, required 12", n_out - base);
      end
   endtask

   task automatic test_throughput();
      int pushes;
      int base;
      for (int k = 0; k < NK; k++) write_kernel(k, rand_vec(), 1'b1);
      relu_en   = 1'b1;
      out_ready = 1'b0;
      base      = n_out;
      for (int i = 0; i < DEPTH; i++) push_window(rand_vec());
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL tp_full: in_ready %b with FIFO full, required 0", in_ready);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      pushes    = 0;
      for (int c = 0; c < 20; c++) begin
         in_data = rand_vec();
         @(negedge clk);
         n_checks++;
         if (in_ready !== (c % 2 == 1) || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL tp_cycle: cycle %0d in_ready %b out_valid %b, required %b and 1",
                     c, in_ready, out_valid, (c % 2 == 1));
         end
         if (in_ready) pushes++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_drain("tp");
      n_checks++;
      if (pushes != 10 || n_out - base != 2 * (DEPTH + 10)) begin
         n_errors++;
         $display("FAIL tp_rate: pushes %0d groups %0d, required 10 and %0d", pushes, n_out - base, 2 * (DEPTH + 10));
      end
      relu_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      load_std_kernels();
      push_window(fill(3));
      push_window(fill(2));
      tick();
      res = 1'b1;
      sb.delete();
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
         n_errors++;
         $display("FAIL rst_mid: got v%b rdy%b %h, required v0 rdy0 0000", out_valid, in_ready, out_data);
      end
      res = 1'b0;
      for (int k = 0; k < NK; k++) kmodel[k] = '0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid_ready: got %b after release, required 1", in_ready);
      end
      push_window(fill(3));
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_group !== 1'b0 || out_data !== '0) begin
         n_errors++;
         $display("FAIL rst_zero_grp0: got v%b g%0d %h, required v1 g0 0000", out_valid, out_group, out_data);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== '0) begin
         n_errors++;
         $display("FAIL rst_zero_grp1: got v%b l%b %h, required v1 l1 0000", out_valid, out_last, out_data);
      end
      wait_drain("rst");
   endtask

   task automatic test_kernel_lock();
      load_std_kernels();
      push_window(fill(3));
      tick(2);
      write_kernel(0, fill(5), 1'b0);
      wait_drain("lock_a");
      push_window(fill(3));
      tick();
      n_checks++;
      if (out_data[0] !== 8'd27) begin
         n_errors++;
         $display("FAIL lock_ignored: got k0 result %0d, required 27", $signed(out_data[0]));
      end
      wait_drain("lock_b");
      write_kernel(0, fill(5), 1'b1);
      push_window(fill(3));
      tick();
      n_checks++;
      if (out_data[0] !== 8'h7f) begin
         n_errors++;
         $display("FAIL lock_idle_write: got k0 result %0d, required 127", $signed(out_data[0]));
      end
      wait_drain("lock_c");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_throughput();
      test_reset_mid();
      test_kernel_lock();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
